// File: rtl/rob_superscalar_pkg.sv
// rob_superscalar_pkg: shared ROB sizing and entry payload type; pc/br fields exist only with ROB_COMMIT_PC_EN
package CDB_types;
  localparam int ROB_DEPTH = 16;
  localparam int DISPATCH_W = 2;
  localparam int COMMIT_W = 2;
  localparam int CDB_NUM = 5;
  localparam int P_REG_NUM = 64;
  localparam int PD_W = $clog2(P_REG_NUM);
  typedef struct packed {
    logic [PD_W-1:0] pd;
    logic [4:0] rd;
`ifdef ROB_COMMIT_PC_EN
    logic [31:0] pc_next;
    logic br_en;
`endif
  } rob_entry_t;
endpackage

// File: rtl/rob_superscalar_commit_scan.sv
// rob_commit_scan: contiguous ready-to-retire lane mask starting at head
module rob_commit_scan #(
  parameter int ROB_DEPTH = CDB_types::ROB_DEPTH,
  parameter int COMMIT_W = CDB_types::COMMIT_W,
  localparam int IW = $clog2(ROB_DEPTH)
) (
  input  logic [IW-1:0]        head_idx,
  input  logic [ROB_DEPTH-1:0] valid,
  input  logic [ROB_DEPTH-1:0] done,
  input  logic [IW:0]          occ,
  output logic [COMMIT_W-1:0]  ready_mask
);
  import CDB_types::*;
  logic run;
  // walk lanes from head and stop at the first entry that cannot retire
  always_comb begin
    ready_mask = '0;
    run = 1'b1;
    for (int j = 0; j < COMMIT_W; j++) begin
      run = run & valid[head_idx + IW'(j)] & done[head_idx + IW'(j)] & ((IW+1)'(j) < occ);
      ready_mask[j] = run;
    end
  end
endmodule

// File: rtl/rob_superscalar.sv
// rob_superscalar: superscalar reorder buffer; define ROB_COMMIT_PC_EN to store and retire pc_next/br_en
module rob_superscalar #(
  parameter int ROB_DEPTH = CDB_types::ROB_DEPTH,
  parameter int DISPATCH_W = CDB_types::DISPATCH_W,
  parameter int COMMIT_W = CDB_types::COMMIT_W,
  parameter int CDB_NUM = CDB_types::CDB_NUM,
  parameter int P_REG_NUM = CDB_types::P_REG_NUM,
  localparam int IW = $clog2(ROB_DEPTH),
  localparam int PW = $clog2(P_REG_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DISPATCH_W-1:0] enq_valid,
  input  logic [PW-1:0]         enq_pd [DISPATCH_W],
  input  logic [4:0]            enq_rd [DISPATCH_W],
  output logic                  enq_ready,
  output logic [IW:0]           enq_rob_idx [DISPATCH_W],
  input  logic [CDB_NUM-1:0]    cdb_we,
  input  logic [IW-1:0]         cdb_rob_idx [CDB_NUM],
  input  logic [31:0]           cdb_pc [CDB_NUM],
  input  logic [CDB_NUM-1:0]    cdb_br_en,
  output logic [COMMIT_W-1:0]   commit_valid,
  output logic [PW-1:0]         commit_pd [COMMIT_W],
  output logic [4:0]            commit_rd [COMMIT_W],
`ifdef ROB_COMMIT_PC_EN
  output logic [31:0]           commit_pc [COMMIT_W],
  output logic [COMMIT_W-1:0]   commit_br_en,
`endif
  input  logic                  flush,
  input  logic [IW:0]           recover_tail,
  output logic [IW:0]           head,
  output logic [IW:0]           tail,
  output logic [IW:0]           free_cnt,
  output logic                  empty,
  output logic                  full
);
  import CDB_types::*;
  logic [IW:0] head_q, tail_q, occ, scan_occ, flush_span, enq_cnt, commit_cnt;
  logic [ROB_DEPTH-1:0] valid_q, done_q;
  logic [COMMIT_W-1:0] commit_mask;
  logic do_enq;
  rob_entry_t mem [ROB_DEPTH];

  assign head = head_q;
  assign tail = tail_q;
  assign occ = tail_q - head_q;
  assign free_cnt = (IW+1)'(ROB_DEPTH) - occ;
  assign empty = head_q == tail_q;
  assign full = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
  assign enq_ready = free_cnt >= (IW+1)'(DISPATCH_W);
  assign do_enq = enq_ready && |enq_valid && !flush;
  assign enq_cnt = (IW+1)'($countones(enq_valid));
  assign commit_cnt = (IW+1)'($countones(commit_mask));
  assign flush_span = tail_q - recover_tail;
  // a flush limits retirement to entries older than recover_tail
  assign scan_occ = flush ? recover_tail - head_q : occ;
  assign commit_valid = commit_mask;

  rob_commit_scan #(.ROB_DEPTH(ROB_DEPTH), .COMMIT_W(COMMIT_W)) u_scan (
    .head_idx  (head_q[IW-1:0]),
    .valid     (valid_q),
    .done      (done_q),
    .occ       (scan_occ),
    .ready_mask(commit_mask)
  );

  // per-lane dispatch tags and retiring payloads
  always_comb begin
    for (int k = 0; k < DISPATCH_W; k++) enq_rob_idx[k] = tail_q + (IW+1)'(k);
    for (int j = 0; j < COMMIT_W; j++) begin
      commit_pd[j] = commit_mask[j] ? mem[head_q[IW-1:0] + IW'(j)].pd : '0;
      commit_rd[j] = commit_mask[j] ? mem[head_q[IW-1:0] + IW'(j)].rd : '0;
    end
  end

`ifdef ROB_COMMIT_PC_EN
  // branch outcome of retiring entries
  always_comb begin
    for (int j = 0; j < COMMIT_W; j++) begin
      commit_pc[j] = commit_mask[j] ? mem[head_q[IW-1:0] + IW'(j)].pc_next : '0;
      commit_br_en[j] = commit_mask[j] ? mem[head_q[IW-1:0] + IW'(j)].br_en : 1'b0;
    end
  end
`else
  logic unused_cdb;
  // branch results have no storage in this build
  always_comb begin
    unused_cdb = ^cdb_br_en;
    for (int i = 0; i < CDB_NUM; i++) unused_cdb = unused_cdb ^ (^cdb_pc[i]);
  end
`endif

  // pointers and valid/done: writeback, then retire, then flush or dispatch (later writes win)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      valid_q <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < CDB_NUM; i++)
        if (cdb_we[i] && valid_q[cdb_rob_idx[i]]) done_q[cdb_rob_idx[i]] <= 1'b1;
      for (int j = 0; j < COMMIT_W; j++)
        if (commit_mask[j]) begin
          valid_q[head_q[IW-1:0] + IW'(j)] <= 1'b0;
          done_q[head_q[IW-1:0] + IW'(j)] <= 1'b0;
        end
      head_q <= head_q + commit_cnt;
      if (flush) begin
        tail_q <= recover_tail;
        for (int i = 0; i < ROB_DEPTH; i++)
          if ({1'b0, IW'(i) - recover_tail[IW-1:0]} < flush_span) begin
            valid_q[i] <= 1'b0;
            done_q[i] <= 1'b0;
          end
      end else if (do_enq) begin
        tail_q <= tail_q + enq_cnt;
        for (int k = 0; k < DISPATCH_W; k++)
          if (enq_valid[k]) begin
            valid_q[tail_q[IW-1:0] + IW'(k)] <= 1'b1;
            done_q[tail_q[IW-1:0] + IW'(k)] <= 1'b0;
          end
      end
    end
  end

  // payload storage, never reset
  always_ff @(posedge clk) begin
`ifdef ROB_COMMIT_PC_EN
    for (int i = 0; i < CDB_NUM; i++)
      if (cdb_we[i] && valid_q[cdb_rob_idx[i]]) begin
        mem[cdb_rob_idx[i]].pc_next <= cdb_pc[i];
        mem[cdb_rob_idx[i]].br_en <= cdb_br_en[i];
      end
`endif
    if (do_enq)
      for (int k = 0; k < DISPATCH_W; k++)
        if (enq_valid[k]) begin
          mem[tail_q[IW-1:0] + IW'(k)].pd <= enq_pd[k];
          mem[tail_q[IW-1:0] + IW'(k)].rd <= enq_rd[k];
        end
  end
endmodule

// File: tb/tb_rob_superscalar.sv
// tb_rob_superscalar: scoreboard bench for rob_superscalar against a queue-based ROB model
module tb_rob_superscalar;
  localparam int D = 16, DW = 2, CW = 2, CN = 5, PW = 6, IW = 4;
  logic clk = 0;
  logic rst = 1;
  logic [DW-1:0] enq_valid;
  logic [PW-1:0] enq_pd [DW];
  logic [4:0] enq_rd [DW];
  logic enq_ready;
  logic [IW:0] enq_rob_idx [DW];
  logic [CN-1:0] cdb_we;
  logic [IW-1:0] cdb_rob_idx [CN];
  logic [31:0] cdb_pc [CN];
  logic [CN-1:0] cdb_br_en;
  logic [CW-1:0] commit_valid;
  logic [PW-1:0] commit_pd [CW];
  logic [4:0] commit_rd [CW];
  logic flush;
  logic [IW:0] recover_tail;
  logic [IW:0] head, tail, free_cnt;
  logic empty, full;

  rob_superscalar #(.ROB_DEPTH(D), .DISPATCH_W(DW), .COMMIT_W(CW), .CDB_NUM(CN), .P_REG_NUM(64)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_pd(enq_pd), .enq_rd(enq_rd),
    .enq_ready(enq_ready), .enq_rob_idx(enq_rob_idx), .cdb_we(cdb_we), .cdb_rob_idx(cdb_rob_idx),
    .cdb_pc(cdb_pc), .cdb_br_en(cdb_br_en), .commit_valid(commit_valid), .commit_pd(commit_pd),
    .commit_rd(commit_rd), .flush(flush), .recover_tail(recover_tail), .head(head), .tail(tail),
    .free_cnt(free_cnt), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {int tag; int pd; int rd; bit done;} ent_t;
  ent_t mq[$];
  int exp_pd[$];
  int exp_rd[$];
  int mhead = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ncom(input bit f, input int rt);
    int lim;
    int c;
    lim = f ? ((rt - mhead) & 31) : mq.size();
    c = 0;
    while (c < CW && c < lim && c < mq.size() && mq[c].done) c++;
    return c;
  endfunction

  initial forever begin
    @(negedge clk);
    if (mon_en) begin : mon
      int n;
      int sz;
      sz = mq.size();
      n = ncom(flush, int'(recover_tail));
      chk("head", int'(head), mhead);
      chk("tail", int'(tail), (mhead + sz) % 32);
      chk("free_cnt", int'(free_cnt), D - sz);
      chk("empty", int'(empty), int'(sz == 0));
      chk("full", int'(full), int'(sz == D));
      chk("enq_ready", int'(enq_ready), int'((D - sz) >= DW));
      for (int k = 0; k < DW; k++) chk("enq_tag", int'(enq_rob_idx[k]), (mhead + sz + k) % 32);
      for (int j = 0; j < CW; j++) begin
        chk("commit_valid", int'(commit_valid[j]), int'(j < n));
        if (commit_valid[j]) begin
          if (exp_pd.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: lane %0d committed with no outstanding entry", j);
          end else begin
            chk("commit_pd", int'(commit_pd[j]), exp_pd.pop_front());
            chk("commit_rd", int'(commit_rd[j]), exp_rd.pop_front());
          end
        end else begin
          chk("idle_pd", int'(commit_pd[j]), 0);
          chk("idle_rd", int'(commit_rd[j]), 0);
        end
      end
    end
  end

  task automatic idle();
    enq_valid = '0;
    cdb_we = '0;
    cdb_br_en = '0;
    flush = 0;
    recover_tail = '0;
    for (int i = 0; i < CN; i++) begin
      cdb_rob_idx[i] = '0;
      cdb_pc[i] = '0;
    end
    for (int k = 0; k < DW; k++) begin
      enq_pd[k] = '0;
      enq_rd[k] = '0;
    end
  endtask

  task automatic model_edge();
    int n, sz, keep, pos;
    n = ncom(flush, int'(recover_tail));
    sz = mq.size();
    for (int i = 0; i < CN; i++)
      if (cdb_we[i]) begin
        pos = (int'(cdb_rob_idx[i]) - mhead) & 15;
        if (pos < sz) mq[pos].done = 1;
      end
    if (flush) begin
      keep = (int'(recover_tail) - mhead) & 31;
      while (mq.size() > keep) begin
        void'(mq.pop_back());
        if (exp_pd.size() > 0) begin
          void'(exp_pd.pop_back());
          void'(exp_rd.pop_back());
        end
      end
    end else if ((D - sz) >= DW && enq_valid != 0) begin
      for (int k = 0; k < DW; k++)
        if (enq_valid[k]) begin
          mq.push_back('{(mhead + sz + k) % 32, int'(enq_pd[k]), int'(enq_rd[k]), 1'b0});
          exp_pd.push_back(int'(enq_pd[k]));
          exp_rd.push_back(int'(enq_rd[k]));
        end
    end
    for (int c = 0; c < n; c++) void'(mq.pop_front());
    mhead = (mhead + n) % 32;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) model_edge();
    idle();
  endtask

  task automatic reset_dut();
    idle();
    rst = 0;
    mq.delete();
    exp_pd.delete();
    exp_rd.delete();
    mhead = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic enq2(input int base);
    enq_valid = 2'b11;
    enq_pd[0] = PW'(base);
    enq_pd[1] = PW'(base + 1);
    enq_rd[0] = 5'(base);
    enq_rd[1] = 5'(base + 3);
    step();
  endtask

  task automatic complete(input logic [15:0] m);
    int p;
    p = 0;
    for (int t = 0; t < D; t++)
      if (m[t]) begin
        if (p == CN) begin
          step();
          p = 0;
        end
        cdb_we[p] = 1;
        cdb_rob_idx[p] = IW'(t);
        cdb_pc[p] = $urandom;
        p++;
      end
    if (p > 0) step();
  endtask

  task automatic complete_pending();
    logic [15:0] m;
    m = '0;
    foreach (mq[i]) if (!mq[i].done) m[mq[i].tag % 16] = 1;
    complete(m);
  endtask

  task automatic drain();
    int b;
    b = 0;
    complete_pending();
    while (mq.size() > 0 && b < 50) begin
      step();
      b++;
    end
    if (mq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d entries left after %0d cycles", mq.size(), b);
    end
  endtask

  task automatic rand_cycle();
    int sz, r, t;
    logic [15:0] used;
    sz = mq.size();
    used = '0;
    r = $urandom % 4;
    enq_valid = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
    for (int k = 0; k < DW; k++) begin
      enq_pd[k] = PW'($urandom);
      enq_rd[k] = 5'($urandom);
    end
    if ($urandom % 16 == 0) begin
      flush = 1;
      recover_tail = 5'((mhead + $urandom_range(0, sz)) % 32);
    end
    for (int i = 0; i < CN; i++)
      if ($urandom % 2 == 0) begin
        t = (sz > 0 && $urandom % 8 != 0) ? mq[$urandom % sz].tag % 16 : $urandom % 16;
        if (!used[t]) begin
          used[t] = 1;
          cdb_we[i] = 1;
          cdb_rob_idx[i] = IW'(t);
          cdb_pc[i] = $urandom;
          cdb_br_en[i] = 1'($urandom);
        end
      end
    step();
  endtask

  initial begin
    idle();
    #2;
    reset_dut();
    mon_en = 1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_free", int'(free_cnt), 16);
    chk("rst_ready", int'(enq_ready), 1);
    chk("rst_commit", int'(commit_valid), 0);
    for (int c = 0; c < 8; c++) begin
      chk("fill_tag0", int'(enq_rob_idx[0]), 2 * c);
      chk("fill_tag1", int'(enq_rob_idx[1]), 2 * c + 1);
      enq2(2 * c);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_ready", int'(enq_ready), 0);
    enq2(60);
    chk("full_tail", int'(tail), 16);
    drain();
    chk("drain_free", int'(free_cnt), 16);
    chk("drain_head", int'(head), 16);

    reset_dut();
    enq2(40);
    enq2(42);
    complete(16'b1110);
    chk("no_commit", int'(commit_valid), 0);
    complete(16'b0001);
    chk("c01_valid", int'(commit_valid), 3);
    chk("c01_pd0", int'(commit_pd[0]), 40);
    chk("c01_pd1", int'(commit_pd[1]), 41);
    chk("c01_rd1", int'(commit_rd[1]), 11);
    step();
    chk("c23_valid", int'(commit_valid), 3);
    chk("c23_pd0", int'(commit_pd[0]), 42);
    chk("c23_rd0", int'(commit_rd[0]), 10);
    step();
    chk("c_empty", int'(empty), 1);

    reset_dut();
    for (int c = 0; c < 7; c++) enq2(c * 2);
    drain();
    enq2(20);
    enq2(30);
    chk("wrap_head", int'(head), 14);
    chk("wrap_tail", int'(tail), 18);
    drain();
    chk("wrap_head2", int'(head), 18);
    chk("wrap_free", int'(free_cnt), 16);

    reset_dut();
    for (int c = 0; c < 5; c++) enq2(c * 4);
    complete(16'h000F);
    repeat (2) step();
    chk("pre_flush_head", int'(head), 4);
    flush = 1;
    recover_tail = 5'd6;
    step();
    chk("flush_tail", int'(tail), 6);
    chk("flush_free", int'(free_cnt), 14);
    cdb_we[0] = 1;
    cdb_rob_idx[0] = 4'd8;
    step();
    complete(16'h0030);
    enq2(50);
    enq2(52);
    complete(16'h00C0);
    repeat (4) step();
    chk("stale_head", int'(head), 8);
    chk("stale_commit", int'(commit_valid), 0);

    enq_valid = 2'b11;
    flush = 1;
    recover_tail = 5'd10;
    step();
    chk("fe_tail", int'(tail), 10);
    chk("fe_free", int'(free_cnt), 14);
    enq_valid = 2'b11;
    flush = 1;
    recover_tail = 5'd8;
    step();
    chk("fe_tail2", int'(tail), 8);
    chk("fe_empty", int'(empty), 1);

    enq2(1);
    enq2(3);
    complete_pending();
    chk("pre_rst_commit", int'(commit_valid), 3);
    #1;
    rst = 0;
    mq.delete();
    exp_pd.delete();
    exp_rd.delete();
    mhead = 0;
    #1;
    chk("mid_rst_commit", int'(commit_valid), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_head", int'(head), 0);
    @(posedge clk);
    #1;
    rst = 1;

    repeat (3000) rand_cycle();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rob_superscalar.md
ROB_SUPERSCALAR -- requirements
Module: rob_superscalar

Interface
REQ-001 Parameters (name, default, meaning): ROB_DEPTH, 16, entries, power of two, at least 4.
REQ-002 DISPATCH_W, 2, enqueue lanes per cycle.
REQ-003 COMMIT_W, 2, retire lanes per cycle, at most ROB_DEPTH.
REQ-004 CDB_NUM, 5, writeback ports.
REQ-005 P_REG_NUM, 64, physical registers. Derived widths: IW = clog2(ROB_DEPTH), PW = clog2(P_REG_NUM).
REQ-006 Ports (name, direction, width, meaning): clk, in, 1, sole clock; rising edge.
REQ-007 rst, in, 1, reset; asynchronous, active-low.
REQ-008 enq_valid[DISPATCH_W], in, 1, per-lane enqueue request; set lanes contiguous from lane 0.
REQ-009 enq_pd[DISPATCH_W], in, PW; enq_rd[DISPATCH_W], in, 5.
REQ-010 enq_ready, out, 1, high when free slots >= DISPATCH_W.
REQ-011 enq_rob_idx[DISPATCH_W], out, IW+1, tag assigned per lane (tail+lane, wrap bit included).
REQ-012 cdb_we[CDB_NUM], in, 1; cdb_rob_idx[CDB_NUM], in, IW; cdb_pc[CDB_NUM], in, 32; cdb_br_en[CDB_NUM], in, 1.
REQ-013 commit_valid[COMMIT_W], out, 1; commit_pd[COMMIT_W], out, PW; commit_rd[COMMIT_W], out, 5.
REQ-014 flush, in, 1; recover_tail, in, IW+1, tail to restore.
REQ-015 head, tail, out, IW+1 each; free_cnt, out, IW+1; empty, full, out, 1 each.

Function
REQ-016 Entry state: valid, done, pd, rd, pc_next, br_en. Pointers carry a wrap bit. empty = (head==tail). full = index bits equal and wrap bits differ. free_cnt = ROB_DEPTH - (tail-head) mod 2^(IW+1).
REQ-017 Enqueue is all-or-nothing. When enq_ready is high and any enq_valid is set, each set lane k writes entry tail+k with valid=1 and done=0. Tail advances by the popcount of enq_valid. Enq_valid while enq_ready is low is ignored.
REQ-018 CDB: cdb_we[i] sets done and records pc_next/br_en for entry cdb_rob_idx[i], only if that entry is valid. Writes to invalid entries are dropped. Multiple ports never target the same entry in one cycle.
REQ-019 Commit is combinational from registered state. Lane j is valid iff entries head..head+j are all valid and done and lie inside the head..tail span. Lanes stop at the first non-ready entry; no gaps. Commit_pd/rd = '0 on invalid lanes.
REQ-020 On the clock edge, committed entries are cleared (valid=0, done=0) and head advances by the count of valid commit lanes.
REQ-021 A CDB write in cycle N makes the entry committable in cycle N+1. There is no same-cycle bypass.
REQ-022 Flush: tail <= recover_tail. Entries from recover_tail up to old tail-1, modulo wrap, are invalidated. Flush overrides enqueue in the same cycle. Commit in the flush cycle proceeds and only ever touches entries older than recover_tail.
REQ-023 recover_tail always lies in head..tail inclusive. If recover_tail equals tail, nothing is invalidated.
REQ-024 Wrap-around: all index arithmetic is modulo ROB_DEPTH on index bits and modulo 2*ROB_DEPTH on full pointers.
REQ-025 Simultaneous enqueue and commit on a full ROB: enq_ready is computed from pre-commit state. Freed slots are usable the following cycle.

Reset
REQ-026 rst low asynchronously clears head, tail, and all valid/done bits. After reset: empty=1, full=0, free_cnt=ROB_DEPTH, enq_ready=1, all commit_valid=0.
REQ-027 Payload fields (pd, rd, pc_next, br_en) need not be reset.
REQ-028 Reset asserted mid-operation discards all in-flight entries with no commits emitted.

Configuration
REQ-029 Macro ROB_COMMIT_PC_EN defined: add ports commit_pc[COMMIT_W] (out, 32) and commit_br_en[COMMIT_W] (out, 1), driven from the entry on valid lanes and '0 otherwise.
REQ-030 ROB_COMMIT_PC_EN undefined: these ports are absent and the pc_next/br_en storage is not built. cdb_pc and cdb_br_en remain as ports and are ignored.

Structure
REQ-031 Shared package CDB_types holds: entry struct rob_entry_t (pd, rd, pc_next, br_en), ROB_DEPTH, P_REG_NUM, CDB_NUM, DISPATCH_W, COMMIT_W.
REQ-032 One sub-module, rob_commit_scan, computes the contiguous-ready commit lane mask from head, the valid/done vectors, and occupancy.

Verification
REQ-033 Reset, enqueue 2 lanes/cycle for 8 cycles -> full=1, enq_ready=0 after cycle 8, tags 0..15.
REQ-034 Enqueue entries 0..3; CDB completes 1, 2, 3 but not 0 -> no commit. Then complete 0 -> next cycle commit lanes 0,1 (entries 0,1), following cycle entries 2,3.
REQ-035 Head=14, tail wrapped to 2 (wrap bit differs); complete all -> commits cross index 15->0 correctly; free_cnt returns to 16.
REQ-036 Tail=10 with entries 4..9 valid; flush with recover_tail=6 -> tail=6, entries 6..9 invalid, a later CDB write to tag 8 is ignored.
REQ-037 Flush and enqueue in the same cycle -> no entry written, tail=recover_tail.
REQ-038 rst pulsed low mid-stream with entries done -> commit_valid all 0 immediately, empty=1.
